sfifo_wr_arb: RTL and testbench
===============================

Name: sfifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of the sfifo between two independent byte producers, e.g. the UART RX path and a command/loopback source.
- Issues registered, one-cycle write pulses to the sfifo.
- Tracks in-flight writes so that the FIFO never overflows.
- Returns a one-cycle acknowledge to each producer per accepted byte.

Parameters:
DW, 8, data width of producer and FIFO data
DEPTH, 8, sfifo capacity in entries
CW, 4, width of sfifo_cnt (must hold 0..DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
req0  input  1  producer 0 has a byte; held high with data0 stable until ack0
data0  input  DW  producer 0 byte
ack0  output  1  one-cycle pulse: data0 accepted
req1  input  1  producer 1 request, same rules as req0
data1  input  DW  producer 1 byte
ack1  output  1  one-cycle pulse: data1 accepted
full  input  1  sfifo full flag
sfifo_cnt  input  CW  sfifo occupancy; updates the cycle after a write is sampled
fifo_wr  output  1  registered write strobe to sfifo
fifo_din  output  DW  registered write data to sfifo
last_gnt  output  1  index of the most recently granted producer

Behaviour:
- Reset (async, rst=1): fifo_wr=0, fifo_din=0, ack0=0, ack1=0, last_gnt=1. With last_gnt=1, producer 0 wins the first contention.
- Eligibility each cycle:
  - elig_i = req_i & ~ack_i. A producer whose ack is high this cycle is masked, because it has not yet removed or updated its data.
- Space check:
  - space = DEPTH - sfifo_cnt - fifo_wr, evaluated at CW+1 bits.
  - A grant is allowed only if space > 0 and full = 0.
  - This covers the one-cycle lag of sfifo_cnt behind fifo_wr.
- Grant, at posedge:
  - Only one eligible producer: grant it.
  - Both eligible: grant the index != last_gnt.
  - No eligible producer, or space check fails: no grant. All outputs return to 0 except fifo_din (holds) and last_gnt (holds).
- On a grant to producer g:
  - fifo_wr <= 1, fifo_din <= data_g, ack_g <= 1, last_gnt <= g.
  - ack and fifo_wr are high in the same cycle, for exactly one cycle.
- Latency: req rising edge to fifo_wr/ack is one clock when space is available.
- Throughput:
  - One write per clock when both producers are active (alternating).
  - A single producer gets at most one write every 2 clocks, due to the ack mask.
- Full / backpressure:
  - While the space check fails, requests wait indefinitely; data must stay stable.
  - No byte is dropped or duplicated.
  - Arbitration order resumes from last_gnt.
- Simultaneous read+write at the sfifo is the sfifo's concern. The arbiter relies only on sfifo_cnt.
- Reset mid-operation: a pending ack/fifo_wr is cleared immediately (async). A byte whose ack never appeared is re-offered by its producer.
- ack0 and ack1 are never both high in the same cycle.

Optional Feature:
- Macro: SFIFO_WR_ARB_STATS_EN.
- When defined:
  - Adds outputs gnt_cnt0[7:0], gnt_cnt1[7:0] and stall_cnt[7:0].
  - gnt_cnt0/gnt_cnt1 increment on each grant to the respective producer.
  - stall_cnt increments each cycle in which any eligible request exists but the space check fails.
  - All three saturate at 255 and reset to 0.
- When undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- Single producer 0, empty FIFO: req0=1 with data0=0xA5 from cycle 0 -> fifo_wr=1 and fifo_din=0xA5 at cycle 1, ack0 one cycle, no duplicate write at cycle 2.
- Contention: req0 and req1 high continuously after reset, data0=0x11, data1=0x22 -> writes alternate 0x11, 0x22, 0x11, ... one per clock; producer 0 is first.
- Fill: req0 streaming with no sfifo reads from sfifo_cnt=0 -> exactly 8 writes, then fifo_wr stays 0 while full=1. After one sfifo read, exactly one more write occurs.
- Near-full lag: sfifo_cnt=7 and fifo_wr=1 in the same cycle, req1 pending -> no grant that cycle (space=0).
- Async reset mid-grant: assert rst while ack1=1 -> ack1, fifo_wr and fifo_din go to 0 immediately; after release, producer 0 wins first contention.
- With SFIFO_WR_ARB_STATS_EN defined: 300 grants to producer 0 -> gnt_cnt0=255 (saturated), gnt_cnt1=0.

Source files
------------

// File: rtl/sfifo_wr_arb.sv
// Round-robin arbiter sharing the sfifo write port between two byte producers.
// Optional grant/stall statistics are enabled with `define SFIFO_WR_ARB_STATS_EN.

// One producer slot: registers its acknowledge and masks itself while acked.
module sfifo_wr_arb_lane (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic ack,
    output logic elig
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack <= 1'b0;
        else     ack <= gnt;
    end

    // The producer still shows the byte just accepted while ack is high.
    assign elig = req & ~ack;
endmodule

module sfifo_wr_arb #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    output logic          ack1,
    input  logic          full,
    input  logic [CW-1:0] sfifo_cnt,
    output logic          fifo_wr,
    output logic [DW-1:0] fifo_din,
`ifdef SFIFO_WR_ARB_STATS_EN
    output logic [7:0]    gnt_cnt0,
    output logic [7:0]    gnt_cnt1,
    output logic [7:0]    stall_cnt,
`endif
    output logic          last_gnt
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]         req_v;
    logic [NUM_LANES-1:0]         ack_v;
    logic [NUM_LANES-1:0]         elig_v;
    logic [NUM_LANES-1:0]         gnt_v;
    logic [NUM_LANES-1:0][DW-1:0] data_v;

    assign req_v  = {req1, req0};
    assign data_v = {data1, data0};
    assign ack0   = ack_v[0];
    assign ack1   = ack_v[1];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sfifo_wr_arb_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .req  (req_v[i]),
            .gnt  (gnt_v[i]),
            .ack  (ack_v[i]),
            .elig (elig_v[i])
        );
    end

    // An in-flight write is not yet visible in sfifo_cnt, so count it as used.
    // Comparing occupancy against DEPTH avoids wrap-around of the difference.
    logic [CW:0] used;
    logic        space_ok;
    assign used     = {1'b0, sfifo_cnt} + (CW+1)'(fifo_wr);
    assign space_ok = (used < (CW+1)'(DEPTH)) && !full;

    logic gnt_idx;
    logic any_gnt;
    always_comb begin
        gnt_idx = elig_v[1];
        if (&elig_v) gnt_idx = ~last_gnt;
        any_gnt = (|elig_v) && space_ok;
        gnt_v   = '0;
        if (any_gnt) gnt_v[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
            last_gnt <= 1'b1;
        end else begin
            fifo_wr <= any_gnt;
            if (any_gnt) begin
                fifo_din <= data_v[gnt_idx];
                last_gnt <= gnt_idx;
            end
        end
    end

`ifdef SFIFO_WR_ARB_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0  <= '0;
            gnt_cnt1  <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_v[0]) gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (gnt_v[1]) gnt_cnt1 <= sat_inc(gnt_cnt1);
            if ((|elig_v) && !space_ok) stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Scoreboard bench for sfifo_wr_arb: random producers and an sfifo occupancy model.
module tb_sfifo_wr_arb;
    localparam int DW = 8, DEPTH = 8, CW = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, full = 1'b0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [CW-1:0] sfifo_cnt = '0;
    logic          ack0, ack1, fifo_wr, last_gnt;
    logic [DW-1:0] fifo_din;
`ifdef SFIFO_WR_ARB_STATS_EN
    logic [7:0]    gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

    sfifo_wr_arb #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .full(full), .sfifo_cnt(sfifo_cnt),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din),
`ifdef SFIFO_WR_ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .stall_cnt(stall_cnt),
`endif
        .last_gnt(last_gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr, a0, a1, last;
        logic [DW-1:0] din;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0, n_bad = 0, n_wr = 0;

    // Reference state: outputs expected after the coming edge, and the current ones.
    bit            n_wr_b, n_a0, n_a1, n_last;
    logic [DW-1:0] n_din;
    bit            m_wr, m_a0, m_a1, m_last;
    int            cnt, cnt_next;
    int            gc0, gc1, stl;

    // Producer behaviour knobs: request probability, fixed data (-1 random), bytes left (-1 endless).
    bit            preq[2];
    logic [DW-1:0] pdat[2];
    int            pgo[2], pfix[2], pleft[2];
    int            rd_pct;

    // Monitor: compares every DUT output cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (fifo_wr) n_wr++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({fifo_wr, ack0, ack1, last_gnt, fifo_din} !== {e.wr, e.a0, e.a1, e.last, e.din}) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: got wr=%0b ack0=%0b ack1=%0b last=%0b din=%02h, expected wr=%0b ack0=%0b ack1=%0b last=%0b din=%02h",
                             $time, fifo_wr, ack0, ack1, last_gnt, fifo_din, e.wr, e.a0, e.a1, e.last, e.din);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus: apply inputs at the falling edge, predict the next rising edge.
    task automatic step();
        bit   rd, e0, e1, ok;
        int   g;
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        m_wr = n_wr_b; m_a0 = n_a0; m_a1 = n_a1; m_last = n_last;
        cnt = cnt_next;
        for (int i = 0; i < 2; i++) begin
            if ((i == 0 && m_a0) || (i == 1 && m_a1)) begin
                preq[i] = 1'b0;
                if (pleft[i] > 0) pleft[i]--;
            end
            if (!preq[i] && pleft[i] != 0 && int'($urandom_range(99)) < pgo[i]) begin
                preq[i] = 1'b1;
                pdat[i] = (pfix[i] >= 0) ? DW'(pfix[i]) : DW'($urandom);
            end
        end
        rd = (cnt > 0) && (int'($urandom_range(99)) < rd_pct);
        req0 = preq[0]; data0 = pdat[0];
        req1 = preq[1]; data1 = pdat[1];
        sfifo_cnt = CW'(cnt);
        full = (cnt >= DEPTH);

        e0 = preq[0] && !m_a0;
        e1 = preq[1] && !m_a1;
        ok = ((DEPTH - cnt - int'(m_wr)) > 0) && !full;
        g = -1;
        if (ok && (e0 || e1)) g = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
        if ((e0 || e1) && !ok && stl < 255) stl++;
        n_wr_b = (g >= 0);
        n_a0 = (g == 0);
        n_a1 = (g == 1);
        if (g >= 0) begin
            n_din  = pdat[g];
            n_last = (g == 1);
            if (g == 0 && gc0 < 255) gc0++;
            if (g == 1 && gc1 < 255) gc1++;
        end
        cnt_next = cnt + int'(m_wr) - int'(rd);
        e.wr = n_wr_b; e.a0 = n_a0; e.a1 = n_a1; e.last = n_last; e.din = n_din;
        exp_q.push_back(e);
    endtask

    // Async reset between edges; outputs must clear at once. Unacked bytes stay offered.
    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({fifo_wr, ack0, ack1, last_gnt, fifo_din} !== {1'b0, 1'b0, 1'b0, 1'b1, {DW{1'b0}}}) begin
            n_bad++;
            $display("FAIL %s: got wr=%0b ack0=%0b ack1=%0b last=%0b din=%02h, expected 0 0 0 1 00",
                     name, fifo_wr, ack0, ack1, last_gnt, fifo_din);
        end
        n_wr_b = 0; n_a0 = 0; n_a1 = 0; n_last = 1; n_din = '0;
        cnt_next = 0; gc0 = 0; gc1 = 0; stl = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic set_prod(input int i, input int go, input int fix, input int left);
        pgo[i] = go; pfix[i] = fix; pleft[i] = left;
    endtask

`ifdef SFIFO_WR_ARB_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, " gnt_cnt0"}, int'(gnt_cnt0), gc0);
        chk({tag, " gnt_cnt1"}, int'(gnt_cnt1), gc1);
        chk({tag, " stall_cnt"}, int'(stall_cnt), stl);
    endtask
`endif

    initial begin
        int w0, k;
        preq[0] = 0; preq[1] = 0; pdat[0] = '0; pdat[1] = '0;
        do_reset("reset_initial");

        // Single producer, one byte 0xA5, no duplicate.
        set_prod(0, 100, 8'hA5, 1); set_prod(1, 0, -1, 0); rd_pct = 0;
        w0 = n_wr;
        repeat (6) step();
        repeat (2) @(posedge clk);
        chk("single_write_count", n_wr - w0, 1);

        // Contention with 0x11 / 0x22, reads keep space open.
        do_reset("reset_contention");
        set_prod(0, 100, 8'h11, -1); set_prod(1, 100, 8'h22, -1); rd_pct = 100;
        repeat (30) step();

        // Fill with producer 0 alone, no reads: exactly DEPTH writes.
        do_reset("reset_fill0");
        preq[0] = 0; preq[1] = 0;
        set_prod(0, 100, -1, -1); set_prod(1, 0, -1, 0); rd_pct = 0;
        w0 = n_wr;
        repeat (40) step();
        @(posedge clk); #3;
        chk("fill_p0_writes", n_wr - w0, DEPTH);

        // Fill with both producers: hits the cnt=7 plus in-flight write case.
        do_reset("reset_fill2");
        set_prod(0, 100, -1, -1); set_prod(1, 100, -1, -1); rd_pct = 0;
        w0 = n_wr;
        repeat (40) step();
        @(posedge clk); #3;
        chk("fill_both_writes", n_wr - w0, DEPTH);
        w0 = n_wr;
        rd_pct = 100; step(); rd_pct = 0;
        repeat (20) step();
        @(posedge clk); #3;
        chk("one_read_one_write", n_wr - w0, 1);
`ifdef SFIFO_WR_ARB_STATS_EN
        chk_stats("fill");
`endif

        // Random traffic with random reads.
        do_reset("reset_random");
        for (int blk = 0; blk < 15; blk++) begin
            set_prod(0, int'($urandom_range(100)), -1, -1);
            set_prod(1, int'($urandom_range(100)), -1, -1);
            rd_pct = int'($urandom_range(100));
            repeat (200) step();
        end

        // Reset while ack1 is high; producer 0 must win afterwards.
        set_prod(0, 100, -1, -1); set_prod(1, 100, -1, -1); rd_pct = 50;
        k = 0;
        do begin step(); k++; end while (!n_a1 && k < 200);
        chk("ack1_reached", int'(n_a1), 1);
        do_reset("reset_mid_ack1");
        repeat (40) step();

        // Long single-producer run for the saturating counters.
        do_reset("reset_stats");
        set_prod(0, 100, -1, -1); set_prod(1, 0, -1, 0); preq[1] = 0; rd_pct = 100;
        repeat (700) step();
        @(posedge clk); #3;
`ifdef SFIFO_WR_ARB_STATS_EN
        chk("gnt_cnt0_saturated", int'(gnt_cnt0), 255);
        chk_stats("sat");
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
